// File: rtl/tail_light_input_cond.sv
// Input conditioner for the tail-light sequencer: synchronises and debounces
// the left/right/hazard switches, generates the slow step tick, and arbitrates
// the debounced levels into mutually exclusive L/R/H requests that change only
// on a tick edge.
// Optional build macro: TLIC_DEBOUNCE_BYPASS_EN removes the debounce counters
// so each debounced level follows its synchroniser output directly.
module tail_light_input_cond #(
    parameter int unsigned TICK_DIV  = 12_500_000,
    parameter int unsigned TICK_W    = 24,
    parameter int unsigned DB_CYCLES = 250_000,
    parameter int unsigned DB_W      = 18
) (
    input  logic clk,
    input  logic reset,
    input  logic left_raw,
    input  logic right_raw,
    input  logic haz_raw,
    output logic tick,
    output logic L,
    output logic R,
    output logic H,
    output logic conflict
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        HAZ   = 2'd3
    } state_t;

    // Bit 0 = left, bit 1 = right, bit 2 = hazard throughout.
    logic [2:0] raw;
    logic [2:0] s1;
    logic [2:0] s2;
    logic [2:0] db;

    assign raw = {haz_raw, right_raw, left_raw};

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

`ifdef TLIC_DEBOUNCE_BYPASS_EN
    assign db = s2;
`else
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [2:0]      db_q;
    logic [DB_W-1:0] cnt [3];

    // Per input: level changes only after DB_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == db_q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    db_q[i] <= s2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign db = db_q;
`endif

    logic [TICK_W-1:0] tcnt;

    // Free-running tick divider, wraps after TICK_DIV cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
        end else if (tcnt == TICK_LAST) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TICK_W'(1);
        end
    end

    assign tick = (tcnt == TICK_LAST);

    state_t state;
    state_t state_nxt;
    logic   l_nxt;
    logic   r_nxt;
    logic   h_nxt;
    logic   conflict_nxt;

    // Arbiter state and registered request outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            L        <= 1'b0;
            R        <= 1'b0;
            H        <= 1'b0;
            conflict <= 1'b0;
        end else begin
            state    <= state_nxt;
            L        <= l_nxt;
            R        <= r_nxt;
            H        <= h_nxt;
            conflict <= conflict_nxt;
        end
    end

    // Next state from the debounced levels sampled in the tick cycle only.
    always_comb begin
        state_nxt    = state;
        l_nxt        = L;
        r_nxt        = R;
        h_nxt        = H;
        conflict_nxt = conflict;
        if (tick) begin
            if (db[2] || (db[0] && db[1])) begin
                state_nxt = HAZ;
            end else if (db[0]) begin
                state_nxt = LEFT;
            end else if (db[1]) begin
                state_nxt = RIGHT;
            end else begin
                state_nxt = IDLE;
            end
            l_nxt        = (state_nxt == LEFT);
            r_nxt        = (state_nxt == RIGHT);
            h_nxt        = (state_nxt == HAZ);
            conflict_nxt = db[0] & db[1] & ~db[2];
        end
    end

endmodule

// File: tb/tb_tail_light_input_cond.sv
// Directed bench for tail_light_input_cond with TICK_DIV=4, DB_CYCLES=3.
// Cycle 0 is the cycle in which reset is released; outputs are sampled on the
// falling edge, and obs packs {tick, L, R, H, conflict}.
module tb_tail_light_input_cond;

    logic clk;
    logic reset;
    logic left_raw;
    logic right_raw;
    logic haz_raw;
    logic tick;
    logic L;
    logic R;
    logic H;
    logic conflict;

    int checks   = 0;
    int failures = 0;
    int cur      = 0;

    logic [4:0] obs;
    logic [4:0] exp_v;
    assign obs = {tick, L, R, H, conflict};

    tail_light_input_cond #(
        .TICK_DIV (4),
        .TICK_W   (2),
        .DB_CYCLES(3),
        .DB_W     (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .left_raw (left_raw),
        .right_raw(right_raw),
        .haz_raw  (haz_raw),
        .tick     (tick),
        .L        (L),
        .R        (R),
        .H        (H),
        .conflict (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold reset for two cycles, then release at a falling edge with the given switches.
    task automatic start(input logic l, input logic r, input logic h);
        reset     = 1'b1;
        left_raw  = 1'b0;
        right_raw = 1'b0;
        haz_raw   = 1'b0;
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        left_raw  = l;
        right_raw = r;
        haz_raw   = h;
        cur       = 0;
    endtask

    task automatic go(input int k);
        while (cur < k) begin
            @(negedge clk);
            cur++;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        left_raw  = 1'b1;
        right_raw = 1'b1;
        haz_raw   = 1'b1;
        repeat (3) @(negedge clk);
        exp_v = 5'b00000;
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", obs, exp_v);
        end
    endtask

`ifndef TLIC_DEBOUNCE_BYPASS_EN
    task automatic test_left_basic();
        start(1'b1, 1'b0, 1'b0);
        exp_v = 5'b00000;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL left_c0 got=%b exp=%b", obs, exp_v); end
        go(3);
        exp_v = 5'b10000;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL left_c3 got=%b exp=%b", obs, exp_v); end
        go(4);
        exp_v = 5'b00000;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL left_c4 got=%b exp=%b", obs, exp_v); end
        go(7);
        exp_v = 5'b10000;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL left_c7 got=%b exp=%b", obs, exp_v); end
        go(8);
        exp_v = 5'b01000;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL left_c8 got=%b exp=%b", obs, exp_v); end
        go(11);
        exp_v = 5'b11000;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL left_c11 got=%b exp=%b", obs, exp_v); end
    endtask

    task automatic test_glitch();
        start(1'b1, 1'b0, 1'b0);
        go(2);
        left_raw = 1'b0;
        go(4);
        checks++;
        if (dut.cnt[0] !== 2'd2) begin failures++; $display("FAIL glitch_cnt_c4 got=%0d exp=2", dut.cnt[0]); end
        go(5);
        checks++;
        if (dut.cnt[0] !== 2'd0) begin failures++; $display("FAIL glitch_cnt_c5 got=%0d exp=0", dut.cnt[0]); end
        go(8);
        exp_v = 5'b00000;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL glitch_c8 got=%b exp=%b", obs, exp_v); end
        go(16);
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL glitch_c16 got=%b exp=%b", obs, exp_v); end
    endtask

    task automatic test_conflict();
        start(1'b1, 1'b1, 1'b0);
        go(7);
        exp_v = 5'b10000;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL conf_c7 got=%b exp=%b", obs, exp_v); end
        go(8);
        exp_v = 5'b00011;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL conf_c8 got=%b exp=%b", obs, exp_v); end
        right_raw = 1'b0;
        go(12);
        exp_v = 5'b00011;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL conf_c12 got=%b exp=%b", obs, exp_v); end
        go(15);
        exp_v = 5'b10011;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL conf_c15 got=%b exp=%b", obs, exp_v); end
        go(16);
        exp_v = 5'b01000;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL conf_c16 got=%b exp=%b", obs, exp_v); end
    endtask

    task automatic test_hazard();
        start(1'b1, 1'b0, 1'b1);
        go(8);
        exp_v = 5'b00010;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL haz_c8 got=%b exp=%b", obs, exp_v); end
        haz_raw = 1'b0;
        go(15);
        exp_v = 5'b10010;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL haz_c15 got=%b exp=%b", obs, exp_v); end
        go(16);
        exp_v = 5'b01000;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL haz_c16 got=%b exp=%b", obs, exp_v); end
    endtask

    task automatic test_mid_reset();
        start(1'b0, 1'b0, 1'b1);
        go(8);
        exp_v = 5'b00010;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL mrst_pre got=%b exp=%b", obs, exp_v); end
        #2;
        reset = 1'b1;
        #1;
        exp_v = 5'b00000;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL mrst_async got=%b exp=%b", obs, exp_v); end
        @(negedge clk);
        reset = 1'b0;
        cur   = 0;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL mrst_c0 got=%b exp=%b", obs, exp_v); end
        go(2);
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL mrst_c2 got=%b exp=%b", obs, exp_v); end
        go(3);
        exp_v = 5'b10000;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL mrst_c3 got=%b exp=%b", obs, exp_v); end
        go(7);
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL mrst_c7 got=%b exp=%b", obs, exp_v); end
        go(8);
        exp_v = 5'b00010;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL mrst_c8 got=%b exp=%b", obs, exp_v); end
    endtask
`else
    task automatic test_bypass();
        start(1'b1, 1'b0, 1'b0);
        go(3);
        exp_v = 5'b10000;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL byp_c3 got=%b exp=%b", obs, exp_v); end
        go(4);
        exp_v = 5'b01000;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL byp_c4 got=%b exp=%b", obs, exp_v); end
        left_raw  = 1'b0;
        right_raw = 1'b1;
        go(7);
        exp_v = 5'b11000;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL byp_c7 got=%b exp=%b", obs, exp_v); end
        go(8);
        exp_v = 5'b00100;
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL byp_c8 got=%b exp=%b", obs, exp_v); end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        left_raw  = 1'b0;
        right_raw = 1'b0;
        haz_raw   = 1'b0;
        test_reset();
`ifndef TLIC_DEBOUNCE_BYPASS_EN
        test_left_basic();
        test_glitch();
        test_conflict();
        test_hazard();
        test_mid_reset();
`else
        test_bypass();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
